// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types, constants and GF(2^8) helpers
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } aes_state_e;

    localparam int    NR    = 10;
    localparam byte_t RCON0 = 8'h01;

    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Column bytes are a0 (top row) .. a3; [2 3 1 1] circulant.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic block_t shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_encrypt_sbox.sv
// rtl/aes_encrypt_sbox.sv - combinational forward AES S-box
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    always_comb begin
        s_o = 8'h00;
        case (a_i)
            8'h00: s_o = 8'h63; 8'h01: s_o = 8'h7c; 8'h02: s_o = 8'h77; 8'h03: s_o = 8'h7b; 8'h04: s_o = 8'hf2; 8'h05: s_o = 8'h6b; 8'h06: s_o = 8'h6f; 8'h07: s_o = 8'hc5;
            8'h08: s_o = 8'h30; 8'h09: s_o = 8'h01; 8'h0a: s_o = 8'h67; 8'h0b: s_o = 8'h2b; 8'h0c: s_o = 8'hfe; 8'h0d: s_o = 8'hd7; 8'h0e: s_o = 8'hab; 8'h0f: s_o = 8'h76;
            8'h10: s_o = 8'hca; 8'h11: s_o = 8'h82; 8'h12: s_o = 8'hc9; 8'h13: s_o = 8'h7d; 8'h14: s_o = 8'hfa; 8'h15: s_o = 8'h59; 8'h16: s_o = 8'h47; 8'h17: s_o = 8'hf0;
            8'h18: s_o = 8'had; 8'h19: s_o = 8'hd4; 8'h1a: s_o = 8'ha2; 8'h1b: s_o = 8'haf; 8'h1c: s_o = 8'h9c; 8'h1d: s_o = 8'ha4; 8'h1e: s_o = 8'h72; 8'h1f: s_o = 8'hc0;
            8'h20: s_o = 8'hb7; 8'h21: s_o = 8'hfd; 8'h22: s_o = 8'h93; 8'h23: s_o = 8'h26; 8'h24: s_o = 8'h36; 8'h25: s_o = 8'h3f; 8'h26: s_o = 8'hf7; 8'h27: s_o = 8'hcc;
            8'h28: s_o = 8'h34; 8'h29: s_o = 8'ha5; 8'h2a: s_o = 8'he5; 8'h2b: s_o = 8'hf1; 8'h2c: s_o = 8'h71; 8'h2d: s_o = 8'hd8; 8'h2e: s_o = 8'h31; 8'h2f: s_o = 8'h15;
            8'h30: s_o = 8'h04; 8'h31: s_o = 8'hc7; 8'h32: s_o = 8'h23; 8'h33: s_o = 8'hc3; 8'h34: s_o = 8'h18; 8'h35: s_o = 8'h96; 8'h36: s_o = 8'h05; 8'h37: s_o = 8'h9a;
            8'h38: s_o = 8'h07; 8'h39: s_o = 8'h12; 8'h3a: s_o = 8'h80; 8'h3b: s_o = 8'he2; 8'h3c: s_o = 8'heb; 8'h3d: s_o = 8'h27; 8'h3e: s_o = 8'hb2; 8'h3f: s_o = 8'h75;
            8'h40: s_o = 8'h09; 8'h41: s_o = 8'h83; 8'h42: s_o = 8'h2c; 8'h43: s_o = 8'h1a; 8'h44: s_o = 8'h1b; 8'h45: s_o = 8'h6e; 8'h46: s_o = 8'h5a; 8'h47: s_o = 8'ha0;
            8'h48: s_o = 8'h52; 8'h49: s_o = 8'h3b; 8'h4a: s_o = 8'hd6; 8'h4b: s_o = 8'hb3; 8'h4c: s_o = 8'h29; 8'h4d: s_o = 8'he3; 8'h4e: s_o = 8'h2f; 8'h4f: s_o = 8'h84;
            8'h50: s_o = 8'h53; 8'h51: s_o = 8'hd1; 8'h52: s_o = 8'h00; 8'h53: s_o = 8'hed; 8'h54: s_o = 8'h20; 8'h55: s_o = 8'hfc; 8'h56: s_o = 8'hb1; 8'h57: s_o = 8'h5b;
            8'h58: s_o = 8'h6a; 8'h59: s_o = 8'hcb; 8'h5a: s_o = 8'hbe; 8'h5b: s_o = 8'h39; 8'h5c: s_o = 8'h4a; 8'h5d: s_o = 8'h4c; 8'h5e: s_o = 8'h58; 8'h5f: s_o = 8'hcf;
            8'h60: s_o = 8'hd0; 8'h61: s_o = 8'hef; 8'h62: s_o = 8'haa; 8'h63: s_o = 8'hfb; 8'h64: s_o = 8'h43; 8'h65: s_o = 8'h4d; 8'h66: s_o = 8'h33; 8'h67: s_o = 8'h85;
            8'h68: s_o = 8'h45; 8'h69: s_o = 8'hf9; 8'h6a: s_o = 8'h02; 8'h6b: s_o = 8'h7f; 8'h6c: s_o = 8'h50; 8'h6d: s_o = 8'h3c; 8'h6e: s_o = 8'h9f; 8'h6f: s_o = 8'ha8;
            8'h70: s_o = 8'h51; 8'h71: s_o = 8'ha3; 8'h72: s_o = 8'h40; 8'h73: s_o = 8'h8f; 8'h74: s_o = 8'h92; 8'h75: s_o = 8'h9d; 8'h76: s_o = 8'h38; 8'h77: s_o = 8'hf5;
            8'h78: s_o = 8'hbc; 8'h79: s_o = 8'hb6; 8'h7a: s_o = 8'hda; 8'h7b: s_o = 8'h21; 8'h7c: s_o = 8'h10; 8'h7d: s_o = 8'hff; 8'h7e: s_o = 8'hf3; 8'h7f: s_o = 8'hd2;
            8'h80: s_o = 8'hcd; 8'h81: s_o = 8'h0c; 8'h82: s_o = 8'h13; 8'h83: s_o = 8'hec; 8'h84: s_o = 8'h5f; 8'h85: s_o = 8'h97; 8'h86: s_o = 8'h44; 8'h87: s_o = 8'h17;
            8'h88: s_o = 8'hc4; 8'h89: s_o = 8'ha7; 8'h8a: s_o = 8'h7e; 8'h8b: s_o = 8'h3d; 8'h8c: s_o = 8'h64; 8'h8d: s_o = 8'h5d; 8'h8e: s_o = 8'h19; 8'h8f: s_o = 8'h73;
            8'h90: s_o = 8'h60; 8'h91: s_o = 8'h81; 8'h92: s_o = 8'h4f; 8'h93: s_o = 8'hdc; 8'h94: s_o = 8'h22; 8'h95: s_o = 8'h2a; 8'h96: s_o = 8'h90; 8'h97: s_o = 8'h88;
            8'h98: s_o = 8'h46; 8'h99: s_o = 8'hee; 8'h9a: s_o = 8'hb8; 8'h9b: s_o = 8'h14; 8'h9c: s_o = 8'hde; 8'h9d: s_o = 8'h5e; 8'h9e: s_o = 8'h0b; 8'h9f: s_o = 8'hdb;
            8'ha0: s_o = 8'he0; 8'ha1: s_o = 8'h32; 8'ha2: s_o = 8'h3a; 8'ha3: s_o = 8'h0a; 8'ha4: s_o = 8'h49; 8'ha5: s_o = 8'h06; 8'ha6: s_o = 8'h24; 8'ha7: s_o = 8'h5c;
            8'ha8: s_o = 8'hc2; 8'ha9: s_o = 8'hd3; 8'haa: s_o = 8'hac; 8'hab: s_o = 8'h62; 8'hac: s_o = 8'h91; 8'had: s_o = 8'h95; 8'hae: s_o = 8'he4; 8'haf: s_o = 8'h79;
            8'hb0: s_o = 8'he7; 8'hb1: s_o = 8'hc8; 8'hb2: s_o = 8'h37; 8'hb3: s_o = 8'h6d; 8'hb4: s_o = 8'h8d; 8'hb5: s_o = 8'hd5; 8'hb6: s_o = 8'h4e; 8'hb7: s_o = 8'ha9;
            8'hb8: s_o = 8'h6c; 8'hb9: s_o = 8'h56; 8'hba: s_o = 8'hf4; 8'hbb: s_o = 8'hea; 8'hbc: s_o = 8'h65; 8'hbd: s_o = 8'h7a; 8'hbe: s_o = 8'hae; 8'hbf: s_o = 8'h08;
            8'hc0: s_o = 8'hba; 8'hc1: s_o = 8'h78; 8'hc2: s_o = 8'h25; 8'hc3: s_o = 8'h2e; 8'hc4: s_o = 8'h1c; 8'hc5: s_o = 8'ha6; 8'hc6: s_o = 8'hb4; 8'hc7: s_o = 8'hc6;
            8'hc8: s_o = 8'he8; 8'hc9: s_o = 8'hdd; 8'hca: s_o = 8'h74; 8'hcb: s_o = 8'h1f; 8'hcc: s_o = 8'h4b; 8'hcd: s_o = 8'hbd; 8'hce: s_o = 8'h8b; 8'hcf: s_o = 8'h8a;
            8'hd0: s_o = 8'h70; 8'hd1: s_o = 8'h3e; 8'hd2: s_o = 8'hb5; 8'hd3: s_o = 8'h66; 8'hd4: s_o = 8'h48; 8'hd5: s_o = 8'h03; 8'hd6: s_o = 8'hf6; 8'hd7: s_o = 8'h0e;
            8'hd8: s_o = 8'h61; 8'hd9: s_o = 8'h35; 8'hda: s_o = 8'h57; 8'hdb: s_o = 8'hb9; 8'hdc: s_o = 8'h86; 8'hdd: s_o = 8'hc1; 8'hde: s_o = 8'h1d; 8'hdf: s_o = 8'h9e;
            8'he0: s_o = 8'he1; 8'he1: s_o = 8'hf8; 8'he2: s_o = 8'h98; 8'he3: s_o = 8'h11; 8'he4: s_o = 8'h69; 8'he5: s_o = 8'hd9; 8'he6: s_o = 8'h8e; 8'he7: s_o = 8'h94;
            8'he8: s_o = 8'h9b; 8'he9: s_o = 8'h1e; 8'hea: s_o = 8'h87; 8'heb: s_o = 8'he9; 8'hec: s_o = 8'hce; 8'hed: s_o = 8'h55; 8'hee: s_o = 8'h28; 8'hef: s_o = 8'hdf;
            8'hf0: s_o = 8'h8c; 8'hf1: s_o = 8'ha1; 8'hf2: s_o = 8'h89; 8'hf3: s_o = 8'h0d; 8'hf4: s_o = 8'hbf; 8'hf5: s_o = 8'he6; 8'hf6: s_o = 8'h42; 8'hf7: s_o = 8'h68;
            8'hf8: s_o = 8'h41; 8'hf9: s_o = 8'h99; 8'hfa: s_o = 8'h2d; 8'hfb: s_o = 8'h0f; 8'hfc: s_o = 8'hb0; 8'hfd: s_o = 8'h54; 8'hfe: s_o = 8'hbb; 8'hff: s_o = 8'h16;
        endcase
    end
endmodule

// File: rtl/aes_encrypt.sv
// rtl/aes_encrypt.sv - iterative AES-128 encryptor, one round per clock
module aes_encrypt
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         aes_start_i,
    input  logic [127:0] aes_key_i,
    input  logic [127:0] aes_msg_dec_i,
    output logic [127:0] aes_msg_enc_o,
    output logic         aes_done_o
);
    aes_state_e state_q;
    logic [3:0] cnt_q;
    byte_t      rcon_q;
    block_t     st_q, rk_q, enc_q;
    logic       done_q;

    block_t      sb_d, sr_d, mc_d, nk_d, round_d, final_d;
    logic [31:0] rot_d, sw_d, t_d, w0_d, w1_d, w2_d, w3_d;

    for (genvar i = 0; i < 16; i++) begin : g_subbytes
        aes_sbox u_sbox (.a_i(st_q[127-8*i -: 8]), .s_o(sb_d[127-8*i -: 8]));
    end

    assign sr_d = shift_rows(sb_d);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mc_d[127-32*c -: 32] = mix_column(sr_d[127-32*c -: 32]);
    end

    // Next round key is derived from the current one in the same cycle it is consumed.
    assign rot_d = rot_word(rk_q[31:0]);
    for (genvar k = 0; k < 4; k++) begin : g_subword
        aes_sbox u_sbox (.a_i(rot_d[31-8*k -: 8]), .s_o(sw_d[31-8*k -: 8]));
    end

    assign t_d  = sw_d ^ {rcon_q, 24'h0};
    assign w0_d = rk_q[127:96] ^ t_d;
    assign w1_d = rk_q[95:64]  ^ w0_d;
    assign w2_d = rk_q[63:32]  ^ w1_d;
    assign w3_d = rk_q[31:0]   ^ w2_d;
    assign nk_d = {w0_d, w1_d, w2_d, w3_d};

    assign round_d = mc_d ^ nk_d;
    assign final_d = sr_d ^ nk_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rcon_q  <= 8'h00;
            st_q    <= '0;
            rk_q    <= '0;
            enc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (aes_start_i) begin
                        st_q    <= aes_msg_dec_i ^ aes_key_i;
                        rk_q    <= aes_key_i;
                        rcon_q  <= RCON0;
                        cnt_q   <= 4'd1;
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (!aes_start_i) begin
                        cnt_q   <= 4'd0;
                        state_q <= S_IDLE;
                    end else begin
                        st_q   <= round_d;
                        rk_q   <= nk_d;
                        rcon_q <= xtime(rcon_q);
                        cnt_q  <= cnt_q + 4'd1;
                        if (cnt_q == 4'(NR - 1)) begin
                            state_q <= S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    cnt_q <= 4'd0;
                    if (!aes_start_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        enc_q   <= final_d;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!aes_start_i) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign aes_msg_enc_o = enc_q;
    assign aes_done_o    = done_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// tb/tb_aes_encrypt.sv - randomized self-checking bench against a FIPS-197 reference model
module tb_aes_encrypt;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key, pt;
    logic [127:0] enc;
    logic         done;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P3 = 128'hece298dcece298dcece298dcece298dc;
    localparam logic [127:0] C3 = 128'hdaec3055df058e1c39e814ea76f6747e;

    aes_encrypt dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .aes_start_i  (start),
        .aes_key_i    (key),
        .aes_msg_dec_i(pt),
        .aes_msg_enc_o(enc),
        .aes_done_o   (done)
    );

    always #5 clk = ~clk;

    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[4*c+r] = gmul(8'h02, s[4*c+r]) ^ gmul(8'h03, s[4*c+(r+1)%4])
                                 ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // Cycle model: edges since START was accepted; completion after the 11th.
    int           phase;
    logic         exp_done;
    logic [127:0] exp_enc, cap_key, cap_pt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase = 0; exp_done = 1'b0; exp_enc = '0;
        end else if (phase == 0) begin
            if (start) begin cap_key = key; cap_pt = pt; phase = 1; end
        end else if (phase < 11) begin
            if (!start) phase = 0;
            else begin
                phase++;
                if (phase == 11) begin
                    exp_enc  = ref_encrypt(cap_key, cap_pt);
                    exp_done = 1'b1;
                end
            end
        end else if (!start) begin
            exp_done = 1'b0; phase = 0;
        end
    end

    always @(negedge clk) begin
        vectors += 2;
        if (done !== exp_done) begin
            miscompares++;
            $display("FAIL cycle_done t=%0t: got %b expected %b", $time, done, exp_done);
        end
        if (enc !== exp_enc) begin
            miscompares++;
            $display("FAIL cycle_enc t=%0t: got %h expected %h", $time, enc, exp_enc);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 30) begin step(); n++; end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_timeout: got done=%b expected 1 within 30 cycles", name, done);
        end
    endtask

    task automatic run(input string name, input logic [127:0] k, input logic [127:0] p, input int hold);
        key = k; pt = p; start = 1'b1;
        wait_done(name);
        repeat (hold) step();
        start = 1'b0;
        step();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] rk, rp;

    initial begin
        rst = 1'b1; start = 1'b0; key = '0; pt = '0;
        build_sbox();
        chk("model_c1", ref_encrypt(K1, P1), C1);
        chk("model_b",  ref_encrypt(K2, P2), C2);
        chk("model_lab", ref_encrypt(K1, P3), C3);
        #12;
        chk("reset_done", {127'd0, done}, 128'd0);
        chk("reset_enc", enc, 128'd0);
        step();
        rst = 1'b0;
        step();

        key = K1; pt = P1; start = 1'b1;
        repeat (10) step();
        chk("latency_edge10", {127'd0, done}, 128'd0);
        step();
        chk("latency_edge11", {127'd0, done}, 128'd1);
        chk("fips_c1", enc, C1);
        repeat (5) step();
        chk("sticky_done", {127'd0, done}, 128'd1);
        chk("sticky_enc", enc, C1);
        start = 1'b0;
        step();
        chk("done_clear", {127'd0, done}, 128'd0);
        chk("enc_held", enc, C1);

        run("fips_b", K2, P2, 0);
        chk("fips_b", enc, C2);
        run("lab", K1, P3, 2);
        chk("lab", enc, C3);

        key = rnd128(); pt = rnd128(); start = 1'b1;
        repeat (5) step();
        start = 1'b0;
        repeat (15) step();
        chk("abort_done", {127'd0, done}, 128'd0);
        chk("abort_enc", enc, C3);

        key = K2; pt = P1; start = 1'b1;
        repeat (7) step();
        rst = 1'b1;
        #1;
        chk("async_rst_done", {127'd0, done}, 128'd0);
        chk("async_rst_enc", enc, 128'd0);
        step();
        rst = 1'b0; start = 1'b0;
        step();
        run("after_reset", K1, P1, 1);
        chk("after_reset", enc, C1);

        key = K2; pt = P2; start = 1'b1;
        step();
        key = rnd128(); pt = rnd128();
        wait_done("input_change");
        chk("input_change", enc, C2);
        start = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            rk = rnd128(); rp = rnd128();
            run("random", rk, rp, int'($urandom_range(0, 3)));
            chk("random", enc, ref_encrypt(rk, rp));
        end

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
